uart_tx_fifo: RTL
=================

# uart_tx_fifo

Byte FIFO and send sequencer sitting directly upstream of the UART transmit controller. Producer logic pushes bytes at full clock rate; the block buffers them and hands them one at a time to the transmitter via its `send`/`data`/`ready` handshake, issuing each `send` as a single-cycle pulse only when the transmitter is idle. This lets firmware-side or state-machine producers emit multi-byte messages without waiting roughly 10 bit times per character.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes; legal range 1..10.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  push request; sampled every cycle.
- `wr_data`  in  8  byte to push.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  DEPTH_LOG2+1  stored byte count; excludes the byte already handed to the transmitter.
- `tx_ready`  in  1  transmitter idle; connects to transmitter `ready`.
- `tx_send`  out  1  one-cycle send strobe; connects to transmitter `send`.
- `tx_data`  out  8  byte for transmitter; connects to transmitter `data`.
- `overflow`  out  1  sticky dropped-write flag (see Configuration).

## Operation
- Storage: 2^DEPTH_LOG2 x 8 array; write and read pointers DEPTH_LOG2 bits, wrapping modulo depth; `count` register is authoritative for `full` and `empty`.
- Push: accepted when `wr_en`=1 and `full`=0, using registered `full` from that cycle. A push while `full`=1 is dropped, the array and `count` are unchanged.
- A push and a pop in the same cycle are both performed; `count` is unchanged and the pointers both advance.
- A push while full is dropped even when a pop occurs in the same cycle.
- Sequencer FSM has four states:
  - IDLE: if `empty`=0 and `tx_ready`=1, pop the head byte into `tx_data`, set `tx_send`=1, go to ISSUE. Otherwise stay.
  - ISSUE: `tx_send`=0, go to WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_ready`=0, then go to WAIT_DONE.
  - WAIT_DONE: stay until `tx_ready`=1, then go to IDLE.
- `tx_data` is registered and holds the popped byte until the next pop.
- `tx_send` is high for exactly one cycle per pop. A new `send` is never issued before the transmitter has been observed busy and then idle again.
- Bytes leave in strict push order. There is no way to drop or reorder them.

## Timing
- Reset values: `tx_send`=0, `tx_data`=8'h00, `full`=0, `empty`=1, `count`=0, `overflow`=0, FSM in IDLE, both pointers 0.
- Reset mid-operation: contents are discarded and any pending handshake is abandoned. The transmitter may finish an in-flight character on its own; this block waits in IDLE for `tx_ready`=1.
- Latency, empty FIFO with idle transmitter: push at edge N; `empty`=0 after N; pop at edge N+1, so `tx_send`=1 and `tx_data` are valid in the cycle after N+1.
- `count` decrements at the same edge that raises `tx_send`.
- Back-to-back byte spacing is the transmitter frame time plus 3 cycles of sequencer overhead: IDLE decision, ISSUE, and WAIT_DONE exit.
- `full`, `empty` and `count` are all registered and update at the same edge.

## Configuration
- `UART_TX_FIFO_OVERFLOW_EN`:
  - Defined: `overflow` is set at the edge after any push attempt with `full`=1. It stays set until `rst`.
  - Undefined: `overflow` is tied to 0 and no flag register exists. Dropping of writes while full is identical in both builds.

## Test plan
- Single byte: after reset, push 8'hA5 with the transmitter idle → exactly one `tx_send` pulse with `tx_data`=8'hA5, issued 2 cycles after the push cycle. `count` returns to 0.
- Burst: push 8'h01..8'h05 on consecutive cycles → five `send` pulses, data in order 01..05. Each pulse follows a `tx_ready` low→high cycle, and no two pulses are closer than frame time + 3 cycles.
- Full and wrap: with DEPTH_LOG2=2 and `tx_ready` held 0, push 8'h10..8'h15.
  - `full`=1 and `count`=4 after the 4th push; bytes 14 and 15 are dropped.
  - With the macro defined, `overflow`=1; without it, `overflow`=0.
  - Release `tx_ready` → output is 10,11,12,13. A further push of 8'h20..8'h23 then drains correctly across the pointer wrap.
- Simultaneous push and pop: push 8'h33 in the same cycle IDLE pops 8'h32 → `count` unchanged, and 8'h33 is the next byte sent.
- Reset mid-burst: assert `rst` while 3 bytes are queued and in WAIT_BUSY → next cycle `count`=0, `empty`=1, `tx_send`=0. No further pulses occur until a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus send sequencer feeding a UART transmitter through its send/data/ready handshake.
// Optional sticky overflow flag: define UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  input  logic                tx_ready,
  output logic                tx_send,
  output logic [7:0]          tx_data,
  output logic                overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && tx_ready) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (!tx_ready) state_next = WAIT_DONE;
      WAIT_DONE: if (tx_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wr_data;
  end

  // tx_send is the registered pop, so it is high exactly during the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_send <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (rst)                overflow_q <= 1'b0;
    else if (wr_en && full) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
